// File: rtl/key_expansion_pkg.sv
// Shared types and constants for the AES-128 key schedule generator.
package key_expansion_pkg;

    localparam int NR_AES128 = 10;
    localparam int WORD_W    = 32;
    localparam int KEY_W     = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYOUT = 2'd1,
        ST_EXPAND = 2'd2
    } state_t;

    // Indexed by i/4; entries 0 and 11..15 are never used by the schedule.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/key_expansion_if.sv
// Request / word-stream / round-key read bundle of the key expansion block.
interface key_expansion_if;
    import key_expansion_pkg::*;

    logic              start;
    logic [0:KEY_W-1]  key_in;
    logic              busy;
    logic              w_valid;
    logic [5:0]        w_idx;
    logic [0:WORD_W-1] w_out;
    logic              done;
    logic              key_ready;
    logic [3:0]        rk_idx;
    logic [0:KEY_W-1]  rk_out;

    modport master (
        output start, key_in, rk_idx,
        input  busy, w_valid, w_idx, w_out, done, key_ready, rk_out
    );

    modport slave (
        input  start, key_in, rk_idx,
        output busy, w_valid, w_idx, w_out, done, key_ready, rk_out
    );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte lookup.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule generator: streams w0..w43 one per cycle and keeps
// the eleven round keys in a registered read store.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | waiting for start; key_ready reflects a completed schedule
//   ST_KEYOUT  | emitting the four key words w0..w3
//   ST_EXPAND  | emitting derived words w4..w43, one per cycle
module key_expansion
    import key_expansion_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic           clk,
    input  logic           rst,
    key_expansion_if.slave bus
);

    localparam logic [5:0] LAST_IDX = 6'(4*(NR+1)-1);

    state_t state_q, state_d;

    // Sliding window: win_q[0] is w[i-4], win_q[3] is w[i-1] for the next word i.
    logic [0:WORD_W-1] win_q [0:3];
    logic [0:WORD_W-1] w_out_q;
    logic [5:0]        w_idx_q;
    logic              key_ready_q;
    logic [0:KEY_W-1]  rk_q;
    logic [0:KEY_W-1]  store_q [0:NR];

    logic [5:0]        nxt_idx;
    logic [0:WORD_W-1] rot_w;
    logic [0:WORD_W-1] sub_w;
    logic [0:WORD_W-1] gen_w;
    logic [0:WORD_W-1] emit_w;
    logic [5:0]        emit_idx;
    logic              emit_en;
    logic              shift_en;
    logic              accept;
    logic              finish;

    assign nxt_idx = w_idx_q + 6'd1;
    assign rot_w   = {win_q[3][8:WORD_W-1], win_q[3][0:7]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*b +: 8]),
            .out_byte (sub_w[8*b +: 8])
        );
    end

    always_comb begin
        gen_w = win_q[0] ^ win_q[3];
        if (nxt_idx[1:0] == 2'd0) begin
            gen_w = win_q[0] ^ sub_w ^ {RCON[nxt_idx[5:2]], 24'h000000};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        emit_en  = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        emit_w   = gen_w;
        emit_idx = nxt_idx;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    emit_en  = 1'b1;
                    emit_w   = bus.key_in[0:WORD_W-1];
                    emit_idx = 6'd0;
                    state_d  = ST_KEYOUT;
                end
            end
            ST_KEYOUT: begin
                emit_en = 1'b1;
                if (w_idx_q[1:0] == 2'd3) begin
                    shift_en = 1'b1;
                    state_d  = ST_EXPAND;
                end else begin
                    emit_w = win_q[nxt_idx[1:0]];
                end
            end
            ST_EXPAND: begin
                if (w_idx_q == LAST_IDX) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    emit_en  = 1'b1;
                    shift_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                win_q[k] <= '0;
            end
            for (int r = 0; r <= NR; r++) begin
                store_q[r] <= '0;
            end
            w_out_q     <= '0;
            w_idx_q     <= '0;
            key_ready_q <= 1'b0;
            rk_q        <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < 4; k++) begin
                    win_q[k] <= bus.key_in[k*WORD_W +: WORD_W];
                end
                key_ready_q <= 1'b0;
            end else if (shift_en) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= win_q[3];
                win_q[3] <= gen_w;
            end
            if (finish) begin
                key_ready_q <= 1'b1;
            end
            if (emit_en) begin
                w_out_q <= emit_w;
                w_idx_q <= emit_idx;
                store_q[emit_idx[5:2]][emit_idx[1:0]*WORD_W +: WORD_W] <= emit_w;
            end
            rk_q <= (bus.rk_idx <= 4'(NR)) ? store_q[bus.rk_idx] : '0;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.w_valid   = (state_q != ST_IDLE);
    assign bus.done      = finish;
    assign bus.w_idx     = w_idx_q;
    assign bus.w_out     = w_out_q;
    assign bus.key_ready = key_ready_q;
    assign bus.rk_out    = rk_q;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: reference schedule built from GF(2^8)
// arithmetic, word scoreboard, round-key table and multi-cycle corner sequences.
module tb_key_expansion;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_expansion_if kif ();

    key_expansion #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] word;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0]  sb   [256];
    logic [31:0] mw   [44];
    logic [31:0] cap_w[44];
    int          done_seen = 0;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   rk;
        logic [127:0] exp_rk;
        logic [31:0]  exp_w4;
    } vec_t;
    vec_t vecs[$];

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_FIPS = 128'h000102030405060708090a0b0c0d0e0f;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic void build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic void model_expand(input logic [127:0] key);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) mw[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = mw[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            mw[i] = mw[i-4] ^ t;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && kif.w_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got idx %0d word %h want no word", kif.w_idx, kif.w_out);
            end else begin
                e = sb_q.pop_front();
                check("w_idx", 128'(kif.w_idx), 128'(e.idx));
                check("w_out", 128'(kif.w_out), 128'(e.word));
                check("done_at_word", 128'(kif.done), 128'(e.idx == 6'd43));
                cap_w[e.idx] = kif.w_out;
            end
        end
        if (kif.done === 1'b1) done_seen++;
    end

    // Drives start at the current cycle T (caller is just after a rising edge),
    // then follows the run for up to 60 cycles. lat = cycle offset of done, -1 if none.
    task automatic run_key(input logic [127:0] key, input int inj_at, input logic [127:0] inj_key,
                           input int rst_at, output int lat, output bit live_ok);
        bit aborted = 1'b0;
        model_expand(key);
        for (int i = 0; i < 44; i++) sb_q.push_back('{6'(i), mw[i]});
        kif.start  = 1'b1;
        kif.key_in = key;
        @(posedge clk); #1;
        kif.start  = 1'b0;
        kif.key_in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        lat     = -1;
        live_ok = 1'b1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            if (c == inj_at) begin
                kif.start  = 1'b1;
                kif.key_in = inj_key;
            end
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1;
                aborted = 1'b1;
                sb_q.delete();
                check("rst_busy",      128'(kif.busy),      128'(0));
                check("rst_w_valid",   128'(kif.w_valid),   128'(0));
                check("rst_done",      128'(kif.done),      128'(0));
                check("rst_key_ready", 128'(kif.key_ready), 128'(0));
                check("rst_w_idx",     128'(kif.w_idx),     128'(0));
                check("rst_w_out",     128'(kif.w_out),     128'(0));
                check("rst_rk_out",    128'(kif.rk_out),    128'(0));
            end
            @(negedge clk);
            if (!aborted && (kif.key_ready !== 1'b0 || kif.busy !== 1'b1)) live_ok = 1'b0;
            if (kif.done === 1'b1) lat = c;
            @(posedge clk); #1;
            kif.start = 1'b0;
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
        kif.rk_idx = idx;
        @(posedge clk); #1;
        val = kif.rk_out;
    endtask

    initial begin
        int           lat;
        bit           live_ok;
        int           done_before;
        logic [127:0] rk_val;
        logic [127:0] key_r;

        rst        = 1'b1;
        kif.start  = 1'b0;
        kif.key_in = '0;
        kif.rk_idx = 4'd0;

        build_sbox();
        vecs.push_back('{KEY_A,    4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 32'ha0fafe17});
        vecs.push_back('{KEY_A,    4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 32'ha0fafe17});
        vecs.push_back('{KEY_A,    4'd0,  KEY_A,                                 32'ha0fafe17});
        vecs.push_back('{128'h0,   4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 32'h62636363});
        vecs.push_back('{128'h0,   4'd11, 128'h0,                                32'h62636363});
        vecs.push_back('{KEY_FIPS, 4'd15, 128'h0,                                32'hd6aa74fd});
        vecs.push_back('{KEY_FIPS, 4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 32'hd6aa74fd});
        vecs.push_back('{KEY_FIPS, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 32'hd6aa74fd});

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",      128'(kif.busy),      128'(0));
        check("reset_w_valid",   128'(kif.w_valid),   128'(0));
        check("reset_done",      128'(kif.done),      128'(0));
        check("reset_key_ready", 128'(kif.key_ready), 128'(0));
        check("reset_w_idx",     128'(kif.w_idx),     128'(0));
        check("reset_w_out",     128'(kif.w_out),     128'(0));
        check("reset_rk_out",    128'(kif.rk_out),    128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[v]) begin
            run_key(vecs[v].key, 0, '0, 0, lat, live_ok);
            check("latency", 128'(lat), 128'(44));
            check("busy_keyready_during_run", 128'(live_ok), 128'(1));
            check("key_ready_after_done", 128'(kif.key_ready), 128'(1));
            check("w4_vector", 128'(cap_w[4]), 128'(vecs[v].exp_w4));
            read_rk(vecs[v].rk, rk_val);
            check("rk_out_vector", rk_val, vecs[v].exp_rk);
            if (vecs[v].rk <= 4'd10) begin
                check("rk_out_model", rk_val,
                      {mw[4*vecs[v].rk], mw[4*vecs[v].rk+1], mw[4*vecs[v].rk+2], mw[4*vecs[v].rk+3]});
            end
        end

        // start at T+10 with another key must not disturb the running schedule
        run_key(KEY_A, 10, KEY_FIPS, 0, lat, live_ok);
        check("ignored_start_latency", 128'(lat), 128'(44));
        check("ignored_start_w4",  128'(cap_w[4]),  128'(32'ha0fafe17));
        check("ignored_start_w8",  128'(cap_w[8]),  128'(32'hf2c295f2));
        check("ignored_start_w43", 128'(cap_w[43]), 128'(32'hb6630ca6));
        read_rk(4'd10, rk_val);
        check("ignored_start_rk10", rk_val, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // reset at T+20 aborts; a fresh start afterwards completes normally
        done_before = done_seen;
        run_key(KEY_FIPS, 0, '0, 20, lat, live_ok);
        check("abort_no_done", 128'(done_seen - done_before), 128'(0));
        check("abort_latency", 128'(lat + 1), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        read_rk(4'd1, rk_val);
        check("abort_store_cleared", rk_val, 128'h0);
        run_key(KEY_A, 0, '0, 0, lat, live_ok);
        check("after_reset_latency", 128'(lat), 128'(44));
        check("after_reset_w43", 128'(cap_w[43]), 128'(32'hb6630ca6));

        // back-to-back: a start in the IDLE cycle right after done
        for (int n = 0; n < 3; n++) begin
            key_r = {$urandom, $urandom, $urandom, $urandom};
            if (n == 0) key_r = 128'h0;
            check("b2b_key_ready_before", 128'(kif.key_ready), 128'(1));
            run_key(key_r, 0, '0, 0, lat, live_ok);
            check("b2b_latency", 128'(lat), 128'(44));
            check("b2b_key_ready_low", 128'(live_ok), 128'(1));
        end
        read_rk(4'd10, rk_val);
        check("b2b_rk10_model", rk_val, {mw[40], mw[41], mw[42], mw[43]});

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
